// File: rtl/wb_seq_pkg.sv
// Shared definitions for the Wishbone bus sequencer: FSM encoding, register
// offsets, bit positions and the timeout result marker.
package wb_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Register offsets, in words (wb_adr_i[5:2])
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PERIOD = 4'h1;
  localparam logic [3:0] OFF_STATUS = 4'h2;

  // Upper two offset bits select a bank; lower two select the entry
  localparam logic [1:0] BANK_MISC     = 2'b00;
  localparam logic [1:0] BANK_ENT_ADR  = 2'b01;
  localparam logic [1:0] BANK_ENT_WDAT = 2'b10;
  localparam logic [1:0] BANK_RESULT   = 2'b11;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_START   = 1;
  localparam int CTRL_LAST_LO = 2;

  localparam int STAT_BUSY   = 1 - 1;
  localparam int STAT_TOERR  = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_SEQ_LO = 8;

  localparam int ENT_WE = 0;
  localparam int ENT_EN = 1;

  // LAST is clamped so the sequence never walks past the implemented table
  function automatic logic [1:0] sat_last(input logic [1:0] v, input int n);
    if (int'(v) > n - 1) return 2'(n - 1);
    return v;
  endfunction

endpackage

// File: rtl/wb_seq_ticker.sv
// Period counter: emits a one-cycle tick every PERIOD cycles while enabled.
module wb_seq_ticker (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] period,
  input  logic        clr,
  output logic        tick
);

  logic [31:0] count;

  assign tick = en && (period != 32'd0) && (count == period - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 32'd0;
    end else if (!en || (period == 32'd0) || clr || tick) begin
      count <= 32'd0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/wb_bus_sequencer.sv
// Wishbone master that replays a small CPU-programmed transaction table on a
// periodic tick or a START write; read results land in shadow registers.
module wb_bus_sequencer
  import wb_seq_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        irq
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] N_ENT = 3'(N_ENTRIES);

  logic        en;
  logic [1:0]  last;
  logic [31:0] period;
  logic        toerr;
  logic        ovr;
  logic [7:0]  seq_count;
  logic [31:0] ent_adr  [N_ENTRIES];
  logic [31:0] ent_wdat [N_ENTRIES];
  logic [31:0] result   [N_ENTRIES];

  state_t          state, state_nxt;
  logic [1:0]      idx;
  logic [TO_W-1:0] tcount;

  logic        acc, wr, rd;
  logic [3:0]  off;
  logic [1:0]  sub;
  logic        ent_ok;
  logic        start_pulse, period_wr, stat_wr;
  logic        tick, trigger, busy;
  logic        ack_hit, to_hit;
  logic [31:0] rd_data;
  logic        unused;

  assign unused = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_sel_i};

  assign acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr     = acc & wb_we_i;
  assign rd     = acc & ~wb_we_i;
  assign off    = wb_adr_i[5:2];
  assign sub    = off[1:0];
  assign ent_ok = {1'b0, sub} < N_ENT;

  assign start_pulse = wr && (off == OFF_CTRL) && wb_dat_i[CTRL_START];
  assign period_wr   = wr && (off == OFF_PERIOD);
  assign stat_wr     = wr && (off == OFF_STATUS);

  assign busy    = (state != S_IDLE);
  assign trigger = tick | start_pulse;
  assign ack_hit = (state == S_WAIT) && m_ack_i;
  assign to_hit  = (state == S_WAIT) && !m_ack_i && (tcount == TO_W'(TIMEOUT - 1));

  assign m_sel_o = 4'hF;
  assign irq     = (state == S_DONE);

  wb_seq_ticker u_ticker (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .clr    (period_wr),
    .tick   (tick)
  );

  always_comb begin
    rd_data = 32'd0;
    case (off[3:2])
      BANK_MISC: begin
        case (off)
          OFF_CTRL:   rd_data = {28'd0, last, 1'b0, en};
          OFF_PERIOD: rd_data = period;
          OFF_STATUS: rd_data = {16'd0, seq_count, 5'd0, ovr, toerr, busy};
          default:    rd_data = 32'd0;
        endcase
      end
      BANK_ENT_ADR:  if (ent_ok) rd_data = ent_adr[sub];
      BANK_ENT_WDAT: if (ent_ok) rd_data = ent_wdat[sub];
      BANK_RESULT:   if (ent_ok) rd_data = result[sub];
      default:       rd_data = 32'd0;
    endcase
  end

  // Slave port, configuration registers and sticky status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 32'd0;
      en        <= 1'b0;
      last      <= 2'd0;
      period    <= 32'd0;
      toerr     <= 1'b0;
      ovr       <= 1'b0;
      seq_count <= 8'd0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        ent_adr[i]  <= 32'd0;
        ent_wdat[i] <= 32'd0;
      end
    end else begin
      wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
      if (rd) wb_dat_o <= rd_data;
      if (wr) begin
        if (off == OFF_CTRL) begin
          en   <= wb_dat_i[CTRL_EN];
          last <= sat_last(wb_dat_i[CTRL_LAST_LO +: 2], N_ENTRIES);
        end
        if (off == OFF_PERIOD) period <= wb_dat_i;
        if (ent_ok && off[3:2] == BANK_ENT_ADR)  ent_adr[sub]  <= wb_dat_i;
        if (ent_ok && off[3:2] == BANK_ENT_WDAT) ent_wdat[sub] <= wb_dat_i;
      end
      // A new event wins over a simultaneous clear
      if (to_hit) toerr <= 1'b1;
      else if (stat_wr && wb_dat_i[STAT_TOERR]) toerr <= 1'b0;
      if (trigger && busy) ovr <= 1'b1;
      else if (stat_wr && wb_dat_i[STAT_OVR]) ovr <= 1'b0;
      if (state == S_DONE) seq_count <= seq_count + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_FETCH;
      S_FETCH: state_nxt = ent_adr[idx][ENT_EN] ? S_WAIT : S_NEXT;
      S_WAIT:  if (ack_hit || to_hit) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (idx == last) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Master port datapath: the NEXT/FETCH states guarantee an idle bus gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      tcount  <= '0;
      m_adr_o <= 32'd0;
      m_dat_o <= 32'd0;
      m_we_o  <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) result[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (trigger) idx <= 2'd0;
        S_FETCH: begin
          if (ent_adr[idx][ENT_EN]) begin
            m_adr_o <= {ent_adr[idx][31:2], 2'b00};
            m_we_o  <= ent_adr[idx][ENT_WE];
            m_dat_o <= ent_wdat[idx];
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            tcount  <= '0;
          end
        end
        S_WAIT: begin
          if (ack_hit) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            if (!m_we_o) result[idx] <= m_dat_i;
          end else if (to_hit) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            if (!m_we_o) result[idx] <= DEAD_BEEF;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        S_NEXT: if (idx != last) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_sequencer.sv
// Scoreboard bench for wb_bus_sequencer: directed register programming, a
// modelled Wishbone slave, and monitors checking slave reads and master cycles.
module tb_wb_bus_sequencer;

  localparam logic [31:0] NOACK_ADR = 32'h7000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack_i = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [64:0] mst_q[$];

  int          cyc_cnt = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] slave_rdata = '0;
  int          irq_cnt = 0;
  int          last_irq = 0, prev_irq = 0;
  logic        irq_prev = 1'b0;
  logic        cyc_prev = 1'b0;
  int          cyc_len = 0;
  int          noack_len = 0;
  logic [31:0] cur_adr = '0;

  wb_bus_sequencer dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_sel_o(m_sel_o), .m_we_o(m_we_o), .m_cyc_o(m_cyc_o),
    .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .irq(irq)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  initial begin
    #(400000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Modelled bus slave on the master port, driven away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      m_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (m_cyc_o && m_stb_o && !m_ack_i) begin
      if (m_adr_o != NOACK_ADR && wait_cnt >= ack_delay) begin
        m_ack_i = 1'b1;
        m_dat_i = m_we_o ? 32'd0 : slave_rdata;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      m_ack_i = 1'b0;
    end
  end

  // Monitor: slave read data, master cycle starts, cycle lengths, irq pulses
  always @(negedge clk) begin
    if (!rst) begin
      cyc_prev = 1'b0;
      cyc_len  = 0;
      irq_prev = 1'b0;
    end else begin
      if (wb_ack_o && !wb_we_i) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%h required=none", wb_dat_o);
        end else begin
          check("rd_data", wb_dat_o, exp_q.pop_front());
        end
      end
      if (m_cyc_o && m_stb_o && !cyc_prev) begin
        cur_adr = m_adr_o;
        if (mst_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mst_unexpected actual=%h required=none", m_adr_o);
        end else begin
          logic [64:0] e;
          e = mst_q.pop_front();
          check("mst_we",  {31'd0, m_we_o}, {31'd0, e[64]});
          check("mst_adr", m_adr_o, e[63:32]);
          check("mst_dat", m_dat_o, e[31:0]);
        end
      end
      if (m_cyc_o) cyc_len++;
      else if (cyc_prev) begin
        if (cur_adr == NOACK_ADR) noack_len = cyc_len;
        cyc_len = 0;
      end
      cyc_prev = m_cyc_o;
      if (irq) begin
        check("irq_single", {31'd0, irq_prev}, 32'd0);
        irq_cnt++;
        prev_irq = last_irq;
        last_irq = cyc_cnt;
      end
      irq_prev = irq;
    end
  end

  // Driver tasks for the slave port
  task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
    int n;
    @(negedge clk);
    wb_adr_i = {26'd0, off, 2'b00};
    wb_dat_i = d;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    if (!wb_ack_o) begin
      checks++; failures++;
      $display("FAIL wr_ack actual=0 required=1");
    end
  endtask

  task automatic wb_read(input logic [3:0] off, input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    @(negedge clk);
    wb_adr_i = {26'd0, off, 2'b00};
    wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic wait_irq(input int target, input int budget);
    int n = 0;
    while (irq_cnt < target && n < budget) begin @(negedge clk); n++; end
    check("irq_count", 32'(irq_cnt), 32'(target));
  endtask

  task automatic wait_cyc(input int budget);
    int n = 0;
    while (!m_cyc_o && n < budget) begin @(negedge clk); n++; end
    check("cyc_start", {31'd0, m_cyc_o}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wb_ack",  {31'd0, wb_ack_o}, 32'd0);
    check("rst_wb_dat",  wb_dat_o, 32'd0);
    check("rst_m_cyc",   {31'd0, m_cyc_o}, 32'd0);
    check("rst_m_stb",   {31'd0, m_stb_o}, 32'd0);
    check("rst_m_we",    {31'd0, m_we_o}, 32'd0);
    check("rst_m_adr",   m_adr_o, 32'd0);
    check("rst_m_dat",   m_dat_o, 32'd0);
    check("rst_irq",     {31'd0, irq}, 32'd0);
    check("m_sel",       {28'd0, m_sel_o}, 32'hF);
    rst = 1'b1;
    wb_read(4'h2, 32'h0000_0000);
    wb_read(4'hC, 32'h0000_0000);
    wb_read(4'h3, 32'h0000_0000);

    // Single read entry triggered by START
    ack_delay = 3; slave_rdata = 32'h0000_00A5;
    wb_write(4'h4, 32'h1000_0006);
    mst_q.push_back({1'b0, 32'h1000_0004, 32'h0000_0000});
    wb_write(4'h0, 32'h0000_0002);
    wait_irq(1, 100);
    wb_read(4'hC, 32'h0000_00A5);
    wb_read(4'h2, 32'h0000_0100);
    wb_read(4'h0, 32'h0000_0000);

    // Periodic: write, skipped entry, read; two periods
    ack_delay = 1; slave_rdata = 32'h1234_5678;
    wb_write(4'h4, 32'h5000_0003);
    wb_write(4'h8, 32'h0000_01F4);
    wb_write(4'h5, 32'h7000_0000);
    wb_write(4'h6, 32'h6000_0002);
    wb_write(4'h1, 32'd100);
    repeat (2) begin
      mst_q.push_back({1'b1, 32'h5000_0000, 32'h0000_01F4});
      mst_q.push_back({1'b0, 32'h6000_0000, 32'h0000_0000});
    end
    wb_write(4'h0, 32'h0000_0009);
    wait_irq(3, 400);
    check("tick_spacing", 32'(last_irq - prev_irq), 32'd100);
    wb_write(4'h0, 32'h0000_0008);
    wb_read(4'h0, 32'h0000_0008);
    wb_read(4'hE, 32'h1234_5678);
    wb_read(4'h2, 32'h0000_0300);

    // Timeout on entry 0, sequence continues to entry 2
    wb_write(4'h4, 32'h7000_0012);
    mst_q.push_back({1'b0, NOACK_ADR, 32'h0000_01F4});
    mst_q.push_back({1'b0, 32'h6000_0000, 32'h0000_0000});
    wb_write(4'h0, 32'h0000_000A);
    wb_read(4'h0, 32'h0000_0008);
    wait_irq(4, 700);
    check("timeout_len", 32'(noack_len), 32'd255);
    wb_read(4'hC, 32'hDEAD_BEEF);
    wb_read(4'h2, 32'h0000_0402);
    wb_write(4'h2, 32'h0000_0002);
    wb_read(4'h2, 32'h0000_0400);

    // Overrun: period shorter than one sequence
    ack_delay = 20;
    wb_write(4'h4, 32'h5000_0003);
    wb_write(4'h1, 32'd10);
    mst_q.push_back({1'b1, 32'h5000_0000, 32'h0000_01F4});
    wb_write(4'h0, 32'h0000_0001);
    wait_cyc(30);
    repeat (12) @(negedge clk);
    wb_write(4'h0, 32'h0000_0000);
    wait_irq(5, 100);
    repeat (40) @(negedge clk);
    check("overrun_irqs", 32'(irq_cnt), 32'd5);
    wb_read(4'h2, 32'h0000_0504);
    wb_write(4'h2, 32'h0000_0004);
    wb_read(4'h2, 32'h0000_0500);

    // START landing on the same edge as a tick
    ack_delay = 1;
    wb_write(4'h1, 32'd100);
    mst_q.push_back({1'b1, 32'h5000_0000, 32'h0000_01F4});
    wb_write(4'h0, 32'h0000_0001);
    repeat (98) @(negedge clk);
    wb_write(4'h0, 32'h0000_0003);
    wait_irq(6, 50);
    wb_write(4'h0, 32'h0000_0000);
    repeat (20) @(negedge clk);
    check("coincide_irqs", 32'(irq_cnt), 32'd6);
    wb_read(4'h2, 32'h0000_0600);

    // Asynchronous reset while waiting for an ack
    wb_write(4'h4, 32'h7000_0012);
    mst_q.push_back({1'b0, NOACK_ADR, 32'h0000_01F4});
    wb_write(4'h0, 32'h0000_0002);
    wait_cyc(10);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("arst_m_stb", {31'd0, m_stb_o}, 32'd0);
    check("arst_m_adr", m_adr_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wb_read(4'h2, 32'h0000_0000);
    wb_read(4'h4, 32'h0000_0000);
    wb_read(4'h1, 32'h0000_0000);
    wb_read(4'h8, 32'h0000_0000);
    repeat (5) @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("mst_q_empty", 32'(mst_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
